// File: rtl/hms_setup_ctrl.sv
// hms_setup_ctrl -- mode/time-setting sequencer for the HMS digital clock.
//
// Synchronises and debounces the MODE/POS/INC push buttons, runs the
// CLOCK / SET_SEC / SET_MIN / SET_HOUR state machine, produces one-cycle
// increment enables for the sec/min/hour counters (normal timekeeping carries
// in CLOCK, button-driven adjustment with auto-repeat in the SET states) and a
// registered digit blank mask that blinks the digit pair being adjusted.
//
// Ports
//   clk, rst_n      system clock; asynchronous active-low reset
//   i_tick_100hz    1-clk pulse, debounce / hold / blink timebase
//   i_tick_1hz      1-clk pulse, timekeeping and SET-state idle timeout
//   i_sw_mode/pos/inc  raw active-low buttons, asynchronous to clk
//   i_max_hit_sec   1-clk pulse, sec counter wrapped (carry into minutes)
//   i_max_hit_min   1-clk pulse, min counter wrapped (carry into hours)
//   o_sec/min/hour_inc  registered 1-clk increment enables
//   o_state         0=CLOCK 1=SET_SEC 2=SET_MIN 3=SET_HOUR
//   o_blank         digit blank mask, 1=blank; [5:4] hour [3:2] min [1:0] sec
module hms_setup_ctrl #(
  parameter int unsigned DEB_SAMPLES  = 3,
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned BLINK_TICKS  = 25,
  parameter int unsigned TIMEOUT_SEC  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_100hz,
  input  logic       i_tick_1hz,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic [1:0] o_state,
  output logic [5:0] o_blank
);

  localparam logic [1:0] ST_CLOCK    = 2'd0;
  localparam logic [1:0] ST_SET_SEC  = 2'd1;
  localparam logic [1:0] ST_SET_MIN  = 2'd2;
  localparam logic [1:0] ST_SET_HOUR = 2'd3;

  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_POS  = 1;
  localparam int unsigned BTN_INC  = 2;

  localparam int unsigned DW   = $clog2(DEB_SAMPLES + 1);
  localparam int unsigned HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned HW   = $clog2(HMAX + 1);
  localparam int unsigned BW   = $clog2(BLINK_TICKS + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_SEC + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST   = HW'(REPEAT_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_SEC - 1);

  // Buttons are handled in "pressed = 1" polarity from the synchroniser on.
  logic [2:0]         raw_press;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         deb_q, deb_d, deb_prev_q;
  logic [2:0][DW-1:0] dcnt_q, dcnt_d;
  logic [2:0]         press;
  logic               mode_ev, pos_ev, inc_ev, any_press;

  logic [1:0]    state_q, state_d;
  logic          in_set, state_chg;
  logic [TW-1:0] to_q, to_d;

  logic          hold_q, hold_d, rep_q, rep_d, rep_fire;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          inc_pulse;

  logic          phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [5:0]    blank_q, blank_d;

  logic sec_inc_q, sec_inc_d, min_inc_q, min_inc_d, hour_inc_q, hour_inc_d;

  assign raw_press = ~{i_sw_inc, i_sw_pos, i_sw_mode};

  // Debounce: the counter tracks consecutive samples that disagree with the
  // debounced level; any agreeing sample restarts it.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (i_tick_100hz) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_d[i] = '0;
        end else if (dcnt_q[i] == DEB_LAST) begin
          deb_d[i]  = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press     = deb_q & ~deb_prev_q;
  assign any_press = |press;
  assign mode_ev   = press[BTN_MODE];
  assign pos_ev    = press[BTN_POS] & ~press[BTN_MODE];
  assign inc_ev    = press[BTN_INC] & ~press[BTN_POS] & ~press[BTN_MODE];

  assign in_set = (state_q != ST_CLOCK);

  // State machine and idle timeout. A press in the same cycle as the final
  // 1 Hz tick counts as activity, so it wins over the timeout.
  always_comb begin
    state_d = state_q;
    if (!in_set) begin
      if (mode_ev) state_d = ST_SET_SEC;
    end else if (mode_ev) begin
      state_d = ST_CLOCK;
    end else if (pos_ev) begin
      state_d = (state_q == ST_SET_HOUR) ? ST_SET_SEC : state_q + 2'd1;
    end else if (i_tick_1hz && !any_press && (to_q == TO_LAST)) begin
      state_d = ST_CLOCK;
    end
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    to_d = to_q;
    if (!in_set || any_press || state_chg) begin
      to_d = '0;
    end else if (i_tick_1hz) begin
      to_d = to_q + 1'b1;
    end
  end

  // Hold / auto-repeat: first HOLD_TICKS ticks after the press, then one
  // pulse every REPEAT_TICKS ticks while INC stays pressed.
  always_comb begin
    hold_d   = hold_q;
    rep_d    = rep_q;
    hcnt_d   = hcnt_q;
    rep_fire = 1'b0;
    if (in_set && inc_ev) begin
      hold_d = 1'b1;
      rep_d  = 1'b0;
      hcnt_d = '0;
    end else if (!in_set || state_chg || mode_ev || pos_ev || !deb_q[BTN_INC]) begin
      hold_d = 1'b0;
      rep_d  = 1'b0;
      hcnt_d = '0;
    end else if (hold_q && i_tick_100hz) begin
      if (hcnt_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
        rep_fire = 1'b1;
        rep_d    = 1'b1;
        hcnt_d   = '0;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  assign inc_pulse = in_set && (inc_ev || rep_fire);

  always_comb begin
    if (in_set) begin
      sec_inc_d  = inc_pulse && (state_q == ST_SET_SEC);
      min_inc_d  = inc_pulse && (state_q == ST_SET_MIN);
      hour_inc_d = inc_pulse && (state_q == ST_SET_HOUR);
    end else begin
      sec_inc_d  = i_tick_1hz;
      min_inc_d  = i_max_hit_sec;
      hour_inc_d = i_max_hit_min;
    end
  end

  // Blink phase restarts visible on every state change and every increment.
  always_comb begin
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (!in_set || state_chg || inc_pulse) begin
      phase_d = 1'b0;
      bcnt_d  = '0;
    end else if (i_tick_100hz) begin
      if (bcnt_q == BLINK_LAST) begin
        phase_d = ~phase_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Mask is built from next-state values so it lines up with o_state.
  always_comb begin
    blank_d = '0;
    case (state_d)
      ST_SET_SEC:  blank_d[1:0] = {2{phase_d}};
      ST_SET_MIN:  blank_d[3:2] = {2{phase_d}};
      ST_SET_HOUR: blank_d[5:4] = {2{phase_d}};
      default:     blank_d      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dcnt_q     <= '0;
      state_q    <= ST_CLOCK;
      to_q       <= '0;
      hold_q     <= 1'b0;
      rep_q      <= 1'b0;
      hcnt_q     <= '0;
      phase_q    <= 1'b0;
      bcnt_q     <= '0;
      blank_q    <= '0;
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hour_inc_q <= 1'b0;
    end else begin
      sync1_q    <= raw_press;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
      state_q    <= state_d;
      to_q       <= to_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      hcnt_q     <= hcnt_d;
      phase_q    <= phase_d;
      bcnt_q     <= bcnt_d;
      blank_q    <= blank_d;
      sec_inc_q  <= sec_inc_d;
      min_inc_q  <= min_inc_d;
      hour_inc_q <= hour_inc_d;
    end
  end

  assign o_state    = state_q;
  assign o_blank    = blank_q;
  assign o_sec_inc  = sec_inc_q;
  assign o_min_inc  = min_inc_q;
  assign o_hour_inc = hour_inc_q;

endmodule
